// File: rtl/vc_fifo_buffer.sv
// Virtual-channel flit buffer: NUM_VC independent FIFOs sharing one storage array, show-ahead read port.
// Optional sticky overflow/underflow flags are compiled in with VC_BUF_ERR_EN.
module vc_fifo_buffer #(
  parameter int unsigned WIDTH  = 18,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NUM_VC = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       wr_en,
  input  logic [$clog2(NUM_VC)-1:0]                  wr_vc,
  input  logic [WIDTH-1:0]                           wr_data,
  input  logic                                       rd_en,
  input  logic [$clog2(NUM_VC)-1:0]                  rd_vc,
  output logic [WIDTH-1:0]                           rd_data,
  output logic [NUM_VC-1:0]                          full,
  output logic [NUM_VC-1:0]                          empty,
  output logic [NUM_VC*($clog2(DEPTH)+1)-1:0]        count,
  output logic                                       err_ovf,
  output logic                                       err_udf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned VW = $clog2(NUM_VC);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned MW = NUM_VC * DEPTH;

  logic [WIDTH-1:0] mem_q [MW];
  logic [AW-1:0]    wr_ptr_q [NUM_VC];
  logic [AW-1:0]    wr_ptr_d [NUM_VC];
  logic [AW-1:0]    rd_ptr_q [NUM_VC];
  logic [AW-1:0]    rd_ptr_d [NUM_VC];
  logic [CW-1:0]    cnt_q    [NUM_VC];
  logic [CW-1:0]    cnt_d    [NUM_VC];
  logic             push_ok;
  logic             pop_ok;

  // Status flags decoded from the registered occupancy counters
  always_comb begin
    full  = '0;
    empty = '0;
    count = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      full[v]              = (cnt_q[v] == CW'(DEPTH));
      empty[v]             = (cnt_q[v] == '0);
      count[v*CW +: CW]    = cnt_q[v];
    end
  end

  assign push_ok = wr_en & ~full[wr_vc];
  assign pop_ok  = rd_en & ~empty[rd_vc];

  // Channel v owns the address block {v, ptr}; pointers wrap naturally at DEPTH
  assign rd_data = mem_q[{rd_vc, rd_ptr_q[rd_vc]}];

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      wr_ptr_d[v] = wr_ptr_q[v];
      rd_ptr_d[v] = rd_ptr_q[v];
      cnt_d[v]    = cnt_q[v];
      if (push_ok && (wr_vc == VW'(v))) begin
        wr_ptr_d[v] = wr_ptr_q[v] + AW'(1);
      end
      if (pop_ok && (rd_vc == VW'(v))) begin
        rd_ptr_d[v] = rd_ptr_q[v] + AW'(1);
      end
      cnt_d[v] = cnt_q[v] + CW'(push_ok && (wr_vc == VW'(v)))
                          - CW'(pop_ok && (rd_vc == VW'(v)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        cnt_q[v]    <= cnt_d[v];
      end
    end
  end

  // Storage is never cleared; reset only makes old words unreachable
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem_q[{wr_vc, wr_ptr_q[wr_vc]}] <= wr_data;
    end
  end

`ifdef VC_BUF_ERR_EN
  logic err_ovf_q;
  logic err_udf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      if (wr_en && full[wr_vc]) err_ovf_q <= 1'b1;
      if (rd_en && empty[rd_vc]) err_udf_q <= 1'b1;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_vc_fifo_buffer.sv
// Self-checking bench for vc_fifo_buffer: directed scenarios plus random traffic against per-channel queue model.
module tb_vc_fifo_buffer;

  localparam int unsigned W  = 18;
  localparam int unsigned D  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned VW = 2;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [VW-1:0] wr_vc;
  logic [W-1:0]  wr_data;
  logic          rd_en;
  logic [VW-1:0] rd_vc;
  logic [W-1:0]  rd_data;
  logic [N-1:0]  full;
  logic [N-1:0]  empty;
  logic [N*CW-1:0] count;
  logic          err_ovf;
  logic          err_udf;

  int n_cmp;
  int n_bad;

  logic [W-1:0] mq [N][$];
  bit m_ovf;
  bit m_udf;

  vc_fifo_buffer #(.WIDTH(W), .DEPTH(D), .NUM_VC(N)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_vc(wr_vc), .wr_data(wr_data),
    .rd_en(rd_en), .rd_vc(rd_vc), .rd_data(rd_data), .full(full), .empty(empty),
    .count(count), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*CW-1:0] exp_count();
    logic [N*CW-1:0] r;
    r = '0;
    for (int v = 0; v < N; v++) r[v*CW +: CW] = CW'(mq[v].size());
    return r;
  endfunction

  function automatic logic [N-1:0] exp_empty();
    logic [N-1:0] r;
    for (int v = 0; v < N; v++) r[v] = (mq[v].size() == 0);
    return r;
  endfunction

  function automatic logic [N-1:0] exp_full();
    logic [N-1:0] r;
    for (int v = 0; v < N; v++) r[v] = (mq[v].size() == D);
    return r;
  endfunction

  function automatic logic exp_ovf();
`ifdef VC_BUF_ERR_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_udf();
`ifdef VC_BUF_ERR_EN
    return m_udf;
`else
    return 1'b0;
`endif
  endfunction

  // One clock of stimulus; the model applies the accept rules to its pre-edge state
  task automatic cycle(input logic r, input logic we, input logic [VW-1:0] wv,
                       input logic [W-1:0] wd, input logic re, input logic [VW-1:0] rv);
    bit pu, po;
    rst = r; wr_en = we; wr_vc = wv; wr_data = wd; rd_en = re; rd_vc = rv;
    @(posedge clk);
    if (r) begin
      for (int v = 0; v < N; v++) mq[v].delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      pu = we && (mq[wv].size() < D);
      po = re && (mq[rv].size() > 0);
      if (we && !pu) m_ovf = 1'b1;
      if (re && !po) m_udf = 1'b1;
      if (po) void'(mq[rv].pop_front());
      if (pu) mq[wv].push_back(wd);
    end
    #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic peek(input logic [VW-1:0] v);
    rd_vc = v;
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 2'd0, '0, 1'b0, 2'd0);
    cycle(1'b1, 1'b1, 2'd1, 18'h1, 1'b1, 2'd1);
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count got %h want 0", count); end
    n_cmp++; if (empty !== 4'hF) begin n_bad++; $display("FAIL reset_empty got %b want 1111", empty); end
    n_cmp++; if (full !== 4'h0) begin n_bad++; $display("FAIL reset_full got %b want 0000", full); end
    n_cmp++; if (err_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", err_ovf); end
    n_cmp++; if (err_udf !== 1'b0) begin n_bad++; $display("FAIL reset_udf got %b want 0", err_udf); end
  endtask

  task automatic test_basic();
    cycle(1'b0, 1'b1, 2'd2, 18'h000A1, 1'b0, 2'd0);
    cycle(1'b0, 1'b1, 2'd2, 18'h000A2, 1'b0, 2'd0);
    n_cmp++; if (count[2*CW +: CW] !== 4'd2) begin n_bad++; $display("FAIL basic_count2 got %0d want 2", count[2*CW +: CW]); end
    n_cmp++; if (empty[2] !== 1'b0) begin n_bad++; $display("FAIL basic_empty2 got %b want 0", empty[2]); end
    peek(2'd2);
    n_cmp++; if (rd_data !== 18'h000A1) begin n_bad++; $display("FAIL basic_head1 got %h want 000a1", rd_data); end
    cycle(1'b0, 1'b0, 2'd0, '0, 1'b1, 2'd2);
    n_cmp++; if (rd_data !== 18'h000A2) begin n_bad++; $display("FAIL basic_head2 got %h want 000a2", rd_data); end
    n_cmp++; if (count !== exp_count()) begin n_bad++; $display("FAIL basic_count got %h want %h", count, exp_count()); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 2'd1, W'($urandom), 1'b0, 2'd0);
    cycle(1'b0, 1'b1, 2'd1, 18'h3FFFF, 1'b0, 2'd0);
    peek(2'd1);
    n_cmp++; if (full[1] !== 1'b1) begin n_bad++; $display("FAIL ovf_full1 got %b want 1", full[1]); end
    n_cmp++; if (count[1*CW +: CW] !== 4'd8) begin n_bad++; $display("FAIL ovf_count1 got %0d want 8", count[1*CW +: CW]); end
    n_cmp++; if (rd_data !== mq[1][0]) begin n_bad++; $display("FAIL ovf_head got %h want %h", rd_data, mq[1][0]); end
    n_cmp++; if (err_ovf !== exp_ovf()) begin n_bad++; $display("FAIL ovf_flag got %b want %b", err_ovf, exp_ovf()); end
  endtask

  task automatic test_underflow();
    cycle(1'b0, 1'b0, 2'd0, '0, 1'b1, 2'd0);
    n_cmp++; if (count !== exp_count()) begin n_bad++; $display("FAIL udf_count got %h want %h", count, exp_count()); end
    n_cmp++; if (empty[0] !== 1'b1) begin n_bad++; $display("FAIL udf_empty0 got %b want 1", empty[0]); end
    n_cmp++; if (err_udf !== exp_udf()) begin n_bad++; $display("FAIL udf_flag got %b want %b", err_udf, exp_udf()); end
  endtask

  task automatic test_same_vc_wrap();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'd3, W'($urandom), 1'b0, 2'd0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 2'd3, W'($urandom), 1'b1, 2'd3);
      n_cmp++; if (count[3*CW +: CW] !== 4'd3) begin n_bad++; $display("FAIL wrap_count3 cyc %0d got %0d want 3", i, count[3*CW +: CW]); end
      n_cmp++; if (rd_data !== mq[3][0]) begin n_bad++; $display("FAIL wrap_head cyc %0d got %h want %h", i, rd_data, mq[3][0]); end
    end
  endtask

  task automatic test_cross_vc();
    for (int i = 0; i < 6; i++) begin
      peek(2'd1);
      n_cmp++; if (rd_data !== mq[1][0]) begin n_bad++; $display("FAIL cross_head1 cyc %0d got %h want %h", i, rd_data, mq[1][0]); end
      cycle(1'b0, 1'b1, 2'd0, W'($urandom), 1'b1, 2'd1);
      n_cmp++; if (count !== exp_count()) begin n_bad++; $display("FAIL cross_count cyc %0d got %h want %h", i, count, exp_count()); end
    end
    for (int i = 0; i < 6; i++) begin
      peek(2'd0);
      n_cmp++; if (rd_data !== mq[0][0]) begin n_bad++; $display("FAIL cross_head0 cyc %0d got %h want %h", i, rd_data, mq[0][0]); end
      cycle(1'b0, 1'b0, 2'd0, '0, 1'b1, 2'd0);
    end
    n_cmp++; if (empty !== exp_empty()) begin n_bad++; $display("FAIL cross_empty got %b want %b", empty, exp_empty()); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'd2, W'($urandom), 1'b0, 2'd0);
    n_cmp++; if (count[2*CW +: CW] !== 4'd5) begin n_bad++; $display("FAIL rstmid_pre got %0d want 5", count[2*CW +: CW]); end
    cycle(1'b1, 1'b1, 2'd2, W'($urandom), 1'b0, 2'd0);
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL rstmid_count got %h want 0", count); end
    n_cmp++; if (empty !== 4'hF) begin n_bad++; $display("FAIL rstmid_empty got %b want 1111", empty); end
    n_cmp++; if (err_ovf !== 1'b0 || err_udf !== 1'b0) begin n_bad++; $display("FAIL rstmid_err got %b%b want 00", err_ovf, err_udf); end
    cycle(1'b0, 1'b0, 2'd0, '0, 1'b0, 2'd0);
    n_cmp++; if (empty !== 4'hF) begin n_bad++; $display("FAIL rstmid_discard got %b want 1111", empty); end
  endtask

  task automatic test_random();
    logic r, we, re;
    logic [VW-1:0] wv, rv;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      we = ($urandom_range(0, 99) < 60);
      re = ($urandom_range(0, 99) < 45);
      wv = VW'($urandom_range(0, N-1));
      rv = VW'($urandom_range(0, N-1));
      cycle(r, we, wv, W'($urandom), re, rv);
      n_cmp++; if (count !== exp_count()) begin n_bad++; $display("FAIL rnd_count cyc %0d got %h want %h", i, count, exp_count()); end
      n_cmp++; if (full !== exp_full() || empty !== exp_empty()) begin n_bad++; $display("FAIL rnd_flags cyc %0d got f%b e%b want f%b e%b", i, full, empty, exp_full(), exp_empty()); end
      n_cmp++; if (err_ovf !== exp_ovf() || err_udf !== exp_udf()) begin n_bad++; $display("FAIL rnd_err cyc %0d got %b%b want %b%b", i, err_ovf, err_udf, exp_ovf(), exp_udf()); end
      if (mq[rv].size() > 0) begin
        n_cmp++; if (rd_data !== mq[rv][0]) begin n_bad++; $display("FAIL rnd_head cyc %0d vc %0d got %h want %h", i, rv, rd_data, mq[rv][0]); end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; m_ovf = 1'b0; m_udf = 1'b0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_vc = '0; rd_vc = '0; wr_data = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_same_vc_wrap();
    test_cross_vc();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
